// File: rtl/pc_unit_ras.sv
// ---------------------------------------------------------------------------
// pc_unit_ras
//
// Fetch-stage program counter with trap entry/return and a circular
// return-address stack (RAS) for call/return prediction. It sits between the
// control unit / ALU and the instruction memory address port.
//
// Parameters:
//   XLEN          width of every PC-related bus
//   RESET_VECTOR  PC loaded by Reset
//   TRAP_VECTOR   PC loaded on trap entry
//   RAS_DEPTH     number of RAS entries (power of two, >= 2)
//   COMPRESSED    non-zero enables +2 sequencing and 2-byte alignment
//
// Ports:
//   CLK              rising-edge clock
//   Reset            synchronous, active-high reset
//   Stall            hold PC, EPC and RAS (trap and mret still act)
//   PCSrc            00 sequential, 01 PCTarget, 10 ALUResult, 11 RAS top
//   PCTarget         branch / JAL target
//   ALUResult        JALR target (bit 0 is cleared)
//   IsCompressed     current instruction is 16-bit
//   TrapReq          take a trap: EPC <= PC, PC <= TRAP_VECTOR
//   MretReq          return from trap: PC <= EPC
//   RasPush          call: push PCPlus4
//   RasPop           return: pop the top entry
//   PC               current fetch address
//   PCPlus4          sequential next address (PC+4 or PC+2)
//   EPC              saved exception PC
//   RasTop           top RAS entry, 0 when the stack is empty
//   RasEmpty         RAS holds no entries
//   MisalignedFault  the selected normal next-PC is misaligned
// ---------------------------------------------------------------------------
module pc_unit_ras #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              RAS_DEPTH    = 4,
    parameter int              COMPRESSED   = 0
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            Stall,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    input  logic [XLEN-1:0] ALUResult,
    input  logic            IsCompressed,
    input  logic            TrapReq,
    input  logic            MretReq,
    input  logic            RasPush,
    input  logic            RasPop,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic [XLEN-1:0] EPC,
    output logic [XLEN-1:0] RasTop,
    output logic            RasEmpty,
    output logic            MisalignedFault
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  epc_q;
    logic [XLEN-1:0]  pc_plus;
    logic [XLEN-1:0]  pc_step;
    logic [XLEN-1:0]  pc_next;
    logic [XLEN-1:0]  ras_top;
    logic             ras_empty;
    logic             normal_upd;
    logic             next_misaligned;

    logic [PTR_W-1:0] ras_ptr_q;
    logic [PTR_W-1:0] ras_ptr_d;
    logic [CNT_W-1:0] ras_cnt_q;
    logic [CNT_W-1:0] ras_cnt_d;
    logic             ras_wr_en;
    logic [PTR_W-1:0] ras_wr_idx;
    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];

    // The normal path is the only one that moves the RAS or can fault;
    // trap and mret override Stall, Reset overrides everything.
    assign normal_upd = !Reset && !TrapReq && !MretReq && !Stall;

    // Sequential step; the +2 step only exists in compressed builds.
    assign pc_step = ((COMPRESSED != 0) && IsCompressed) ? XLEN'(2) : XLEN'(4);
    assign pc_plus = pc_q + pc_step;

    // The top entry is only meaningful while the stack holds something.
    assign ras_empty = (ras_cnt_q == '0);
    assign ras_top   = ras_empty ? '0 : ras_mem[ras_ptr_q];

    // Normal next-PC select. A return with an empty stack has nothing to
    // predict, so it falls through to the sequential address.
    always_comb begin
        pc_next = pc_plus;
        unique case (PCSrc)
            2'b00: pc_next = pc_plus;
            2'b01: pc_next = PCTarget;
            2'b10: pc_next = {ALUResult[XLEN-1:1], 1'b0};
            2'b11: pc_next = ras_empty ? pc_plus : ras_top;
            default: pc_next = pc_plus;
        endcase
    end

    assign next_misaligned = (COMPRESSED != 0) ? pc_next[0]
                                               : (pc_next[1:0] != 2'b00);

    // The fault is reported but the PC still loads the misaligned value;
    // the trap controller follows up with TrapReq on the next cycle.
    assign MisalignedFault = normal_upd && next_misaligned;

    // RAS next-state. The pointer always addresses the current top, so a
    // push writes one slot above it and a pop just steps back. When the
    // stack is full the pointer wraps onto the oldest entry and overwrites
    // it. A simultaneous push and pop replaces the top in place.
    always_comb begin
        ras_ptr_d  = ras_ptr_q;
        ras_cnt_d  = ras_cnt_q;
        ras_wr_en  = 1'b0;
        ras_wr_idx = ras_ptr_q;
        if (normal_upd) begin
            if (RasPush && RasPop && !ras_empty) begin
                ras_wr_en  = 1'b1;
                ras_wr_idx = ras_ptr_q;
            end else if (RasPush) begin
                ras_wr_en  = 1'b1;
                ras_wr_idx = ras_ptr_q + PTR_W'(1);
                ras_ptr_d  = ras_ptr_q + PTR_W'(1);
                if (ras_cnt_q != CNT_W'(RAS_DEPTH)) begin
                    ras_cnt_d = ras_cnt_q + CNT_W'(1);
                end
            end else if (RasPop && !ras_empty) begin
                ras_ptr_d = ras_ptr_q - PTR_W'(1);
                ras_cnt_d = ras_cnt_q - CNT_W'(1);
            end
        end
    end

    // PC / EPC register with priority Reset > trap > mret > stall > normal.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q  <= RESET_VECTOR;
            epc_q <= '0;
        end else if (TrapReq) begin
            pc_q  <= TRAP_VECTOR;
            epc_q <= pc_q;
        end else if (MretReq) begin
            pc_q  <= epc_q;
        end else if (!Stall) begin
            pc_q  <= pc_next;
        end
    end

    // RAS bookkeeping; next-state already holds when not a normal update.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    // Entry storage is qualified by the count, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (ras_wr_en) begin
            ras_mem[ras_wr_idx] <= pc_plus;
        end
    end

    assign PC       = pc_q;
    assign PCPlus4  = pc_plus;
    assign EPC      = epc_q;
    assign RasTop   = ras_top;
    assign RasEmpty = ras_empty;

endmodule
